// File: rtl/qbert_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qbert_pkg
//  Description : Shared definitions for the Q*bert jump controller: jump
//                code encoding, pyramid edge masks (1-based cube numbers,
//                bit 0 = TOP) and the pyramid size helper.
//  Revision    : 1.0  initial release
// ============================================================================
package qbert_pkg;

    localparam int N_ROWS_DEF = 7;

    typedef enum logic [2:0] {
        JMP_NONE   = 3'd0,
        DOWN_RIGHT = 3'd1,
        DOWN_LEFT  = 3'd2,
        UP_RIGHT   = 3'd3,
        UP_LEFT    = 3'd4
    } jump_code_e;

    localparam logic [31:0] TOP = 32'h0000_0001;

    // Right edge (k = 1)
    localparam logic [31:0] R02 = 32'h0000_0002;
    localparam logic [31:0] R04 = 32'h0000_0008;
    localparam logic [31:0] R07 = 32'h0000_0040;
    localparam logic [31:0] R11 = 32'h0000_0400;
    localparam logic [31:0] R16 = 32'h0000_8000;
    localparam logic [31:0] R22 = 32'h0020_0000;

    // Left edge (k = r)
    localparam logic [31:0] L03 = 32'h0000_0004;
    localparam logic [31:0] L06 = 32'h0000_0020;
    localparam logic [31:0] L10 = 32'h0000_0200;
    localparam logic [31:0] L15 = 32'h0000_4000;
    localparam logic [31:0] L21 = 32'h0010_0000;
    localparam logic [31:0] L28 = 32'h0800_0000;

    function automatic int cube_count(input int rows);
        return rows * (rows + 1) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qb_cube_map.sv
`default_nettype none
// ============================================================================
//  Module      : qb_cube_map
//  Description : Combinational (row, k) to one-hot cube decoder.
//                Cube index = r(r-1)/2 + k - 1. Coordinates outside the
//                pyramid decode to all zeros.
//  Ports       : row  - row number, 1..N_ROWS
//                k    - index within row, 1..row
//                cube - one-hot cube vector
//  Revision    : 1.0  initial release
// ============================================================================
module qb_cube_map
    import qbert_pkg::*;
#(
    parameter int N_ROWS = N_ROWS_DEF,
    parameter int N_CUBE = cube_count(N_ROWS)
) (
    input  logic [3:0]        row,
    input  logic [3:0]        k,
    output logic [N_CUBE-1:0] cube
);

    logic [7:0] row8;
    logic [7:0] k8;
    logic [7:0] idx;
    logic       valid;

    always_comb begin
        row8  = {4'd0, row};
        k8    = {4'd0, k};
        idx   = ((row8 * (row8 - 8'd1)) >> 1) + k8 - 8'd1;
        valid = (row8 >= 8'd1) && (row8 <= 8'(N_ROWS)) &&
                (k8 >= 8'd1) && (k8 <= row8);
        cube  = '0;
        for (int i = 0; i < N_CUBE; i++) begin
            if (valid && (idx == 8'(i))) begin
                cube[i] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/qbert_jump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : qbert_jump_ctrl
//  Description : Issues jump commands to the Q*bert display layer, tracks
//                the current cube, the visited mask and the win condition.
//  Ports       : clk, reset (async, active-low)
//                game_run, dir_req, done_move_qb   - request / layer status
//                e_respawn, e_restart, sc_arrive   - placement events
//                position_qb, e_next_qb            - current / target cube
//                e_jump_qb, e_bad_jump             - jump command to layer
//                cube_visited, win_qb, jump_err    - progress and status
//  Revision    : 1.0  initial release
// ============================================================================
module qbert_jump_ctrl
    import qbert_pkg::*;
#(
    parameter int  N_ROWS        = N_ROWS_DEF,
    parameter int  START_TIMEOUT = 1024,
    localparam int N_CUBE        = cube_count(N_ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              game_run,
    input  logic [2:0]        dir_req,
    input  logic              done_move_qb,
    input  logic              e_respawn,
    input  logic              e_restart,
    input  logic              sc_arrive,
    output logic [N_CUBE-1:0] position_qb,
    output logic [N_CUBE-1:0] e_next_qb,
    output logic [2:0]        e_jump_qb,
    output logic              e_bad_jump,
    output logic [N_CUBE-1:0] cube_visited,
    output logic              win_qb,
    output logic              jump_err
);

    localparam int                 CNT_W    = $clog2(START_TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [N_CUBE-1:0]  TOP_CUBE = N_CUBE'(TOP);
    localparam logic signed [3:0]  ROWS_S   = 4'(N_ROWS);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_ISSUE      = 2'd1;
    localparam logic [1:0] S_WAIT_START = 2'd2;
    localparam logic [1:0] S_WAIT_END   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [3:0]        row_q, k_q;
    logic [3:0]        tgt_row_q, tgt_k_q;
    logic              on_board_q;
    logic [CNT_W-1:0]  cnt_q;

    logic signed [3:0] r_s, k_s, nr, nk;
    logic              code_ok, tgt_bad, start, timeout;
    logic [N_CUBE-1:0] cur_cube, tgt_cube;

    // Target coordinates. 4-bit signed wrap (7+1 -> -8) still lands below 1,
    // so an overflow past the bottom row is caught by the same range test.
    always_comb begin
        r_s     = signed'(row_q);
        k_s     = signed'(k_q);
        nr      = r_s;
        nk      = k_s;
        code_ok = 1'b1;
        case (dir_req)
            DOWN_RIGHT: nr = r_s + 4'sd1;
            DOWN_LEFT: begin
                nr = r_s + 4'sd1;
                nk = k_s + 4'sd1;
            end
            UP_RIGHT: begin
                nr = r_s - 4'sd1;
                nk = k_s - 4'sd1;
            end
            UP_LEFT:  nr = r_s - 4'sd1;
            // Codes 0 and 5..7 carry no direction and never start a jump
            default:  code_ok = 1'b0;
        endcase
        tgt_bad = (nr < 4'sd1) || (nr > ROWS_S) || (nk < 4'sd1) || (nk > nr);
    end

    qb_cube_map #(.N_ROWS(N_ROWS), .N_CUBE(N_CUBE)) u_cur_map (
        .row  (row_q),
        .k    (k_q),
        .cube (cur_cube)
    );

    qb_cube_map #(.N_ROWS(N_ROWS), .N_CUBE(N_CUBE)) u_tgt_map (
        .row  (nr),
        .k    (nk),
        .cube (tgt_cube)
    );

    assign start   = game_run && code_ok && done_move_qb && on_board_q &&
                     !sc_arrive && !e_respawn && !e_restart;
    assign timeout = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (e_restart || e_respawn) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:       if (start) state_d = S_ISSUE;
                S_ISSUE:      state_d = S_WAIT_START;
                S_WAIT_START: begin
                    if (!done_move_qb) state_d = S_WAIT_END;
                    else if (timeout)  state_d = S_IDLE;
                end
                S_WAIT_END:   if (done_move_qb) state_d = S_IDLE;
                default:      state_d = S_IDLE;
            endcase
        end
    end

    // Output decode: off-board is carried by a flag, not by row/k
    assign position_qb = on_board_q ? cur_cube : '0;

    // Registered jump outputs and position bookkeeping. The jump command is
    // loaded on the request edge so it is already visible during ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q        <= 4'd1;
            k_q          <= 4'd1;
            tgt_row_q    <= 4'd1;
            tgt_k_q      <= 4'd1;
            on_board_q   <= 1'b1;
            cnt_q        <= '0;
            e_next_qb    <= TOP_CUBE;
            e_jump_qb    <= 3'd0;
            e_bad_jump   <= 1'b0;
            cube_visited <= TOP_CUBE;
            win_qb       <= 1'b0;
            jump_err     <= 1'b0;
        end else begin
            win_qb <= win_qb | (&cube_visited);
            if (e_restart || e_respawn) begin
                row_q      <= 4'd1;
                k_q        <= 4'd1;
                on_board_q <= 1'b1;
                e_next_qb  <= TOP_CUBE;
                e_jump_qb  <= 3'd0;
                e_bad_jump <= 1'b0;
                if (e_restart) begin
                    cube_visited <= TOP_CUBE;
                    win_qb       <= 1'b0;
                    jump_err     <= 1'b0;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (sc_arrive) begin
                            row_q      <= 4'd1;
                            k_q        <= 4'd1;
                            on_board_q <= 1'b1;
                            e_next_qb  <= TOP_CUBE;
                        end else if (start) begin
                            e_jump_qb  <= dir_req;
                            e_bad_jump <= tgt_bad;
                            e_next_qb  <= tgt_bad ? '0 : tgt_cube;
                            tgt_row_q  <= nr;
                            tgt_k_q    <= nk;
                        end
                    end
                    S_ISSUE: cnt_q <= '0;
                    S_WAIT_START: begin
                        if (done_move_qb && timeout) begin
                            jump_err   <= 1'b1;
                            e_jump_qb  <= 3'd0;
                            e_bad_jump <= 1'b0;
                            e_next_qb  <= position_qb;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_WAIT_END: begin
                        if (done_move_qb) begin
                            // e_next_qb already equals the new position
                            // (target cube, or zero for a bad jump)
                            if (e_bad_jump) begin
                                on_board_q <= 1'b0;
                            end else begin
                                row_q        <= tgt_row_q;
                                k_q          <= tgt_k_q;
                                cube_visited <= cube_visited | e_next_qb;
                            end
                            e_jump_qb  <= 3'd0;
                            e_bad_jump <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qbert_jump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qbert_jump_ctrl
//  Description : Directed self-checking bench for qbert_jump_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_qbert_jump_ctrl;
    import qbert_pkg::*;

    localparam int N_CUBE = 28;

    logic              clk = 1'b0;
    logic              reset;
    logic              game_run;
    logic [2:0]        dir_req;
    logic              done_move_qb;
    logic              e_respawn;
    logic              e_restart;
    logic              sc_arrive;
    logic [N_CUBE-1:0] position_qb;
    logic [N_CUBE-1:0] e_next_qb;
    logic [2:0]        e_jump_qb;
    logic              e_bad_jump;
    logic [N_CUBE-1:0] cube_visited;
    logic              win_qb;
    logic              jump_err;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] DL_EXP [6] = '{L03, L06, L10, L15, L21, L28};
    // Scripted tour covering every cube, ending on cube 28
    localparam logic [2:0] PATH [30] = '{
        3'd1, 3'd1, 3'd4, 3'd2, 3'd4, 3'd2,
        3'd2, 3'd2,
        3'd3, 3'd1, 3'd3, 3'd1, 3'd3, 3'd1, 3'd3, 3'd1,
        3'd1, 3'd1,
        3'd4, 3'd2, 3'd4, 3'd2, 3'd4, 3'd2, 3'd4, 3'd2, 3'd4, 3'd2, 3'd4, 3'd2
    };

    qbert_jump_ctrl #(.N_ROWS(7), .START_TIMEOUT(1024)) dut (
        .clk          (clk),
        .reset        (reset),
        .game_run     (game_run),
        .dir_req      (dir_req),
        .done_move_qb (done_move_qb),
        .e_respawn    (e_respawn),
        .e_restart    (e_restart),
        .sc_arrive    (sc_arrive),
        .position_qb  (position_qb),
        .e_next_qb    (e_next_qb),
        .e_jump_qb    (e_jump_qb),
        .e_bad_jump   (e_bad_jump),
        .cube_visited (cube_visited),
        .win_qb       (win_qb),
        .jump_err     (jump_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full handshake: request, ISSUE checks, layer busy 3 cycles, commit
    task automatic do_jump(input logic [2:0] code, input logic chk,
                           input logic [31:0] exp_next, input logic exp_bad,
                           input string tag);
        dir_req = code;
        tick();
        dir_req = 3'd0;
        if (chk) begin
            check({tag, "_jump"}, 32'(e_jump_qb), 32'(code));
            check({tag, "_next"}, 32'(e_next_qb), exp_next);
            check({tag, "_bad"},  32'(e_bad_jump), 32'(exp_bad));
        end
        tick();
        done_move_qb = 1'b0;
        tick();
        tick();
        tick();
        done_move_qb = 1'b1;
        tick();
    endtask

    task automatic pulse_respawn();
        e_respawn = 1'b1;
        tick();
        e_respawn = 1'b0;
    endtask

    task automatic pulse_restart();
        e_restart = 1'b1;
        tick();
        e_restart = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset        = 1'b0;
        game_run     = 1'b1;
        dir_req      = 3'd0;
        done_move_qb = 1'b1;
        e_respawn    = 1'b0;
        e_restart    = 1'b0;
        sc_arrive    = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Reset state
        check("rst_pos",     32'(position_qb),  32'h1);
        check("rst_next",    32'(e_next_qb),    32'h1);
        check("rst_visited", 32'(cube_visited), 32'h1);
        check("rst_jump",    32'(e_jump_qb),    32'h0);
        check("rst_bad",     32'(e_bad_jump),   32'h0);
        check("rst_win",     32'(win_qb),       32'h0);
        check("rst_err",     32'(jump_err),     32'h0);

        // First jump DOWN_RIGHT, layer busy 10 cycles
        dir_req = 3'd1;
        tick();
        dir_req = 3'd0;
        check("dr_jump", 32'(e_jump_qb),  32'h1);
        check("dr_next", 32'(e_next_qb),  32'h2);
        check("dr_bad",  32'(e_bad_jump), 32'h0);
        tick();
        tick();
        done_move_qb = 1'b0;
        repeat (10) tick();
        check("dr_hold_jump", 32'(e_jump_qb), 32'h1);
        done_move_qb = 1'b1;
        tick();
        check("dr_pos",     32'(position_qb),  32'h2);
        check("dr_visited", 32'(cube_visited), 32'h3);
        check("dr_jump0",   32'(e_jump_qb),    32'h0);
        check("dr_next_pos",32'(e_next_qb),    32'h2);

        // game_run=0 and a busy layer both block new requests
        game_run = 1'b0;
        dir_req  = 3'd2;
        repeat (3) tick();
        check("norun_jump", 32'(e_jump_qb), 32'h0);
        game_run     = 1'b1;
        done_move_qb = 1'b0;
        repeat (2) tick();
        check("busy_jump", 32'(e_jump_qb), 32'h0);
        dir_req      = 3'd0;
        done_move_qb = 1'b1;
        tick();

        // Respawn keeps the visited mask
        pulse_respawn();
        check("respawn_pos",     32'(position_qb),  32'h1);
        check("respawn_visited", 32'(cube_visited), 32'h3);

        // Off-board jump from TOP
        do_jump(3'd3, 1'b1, 32'h0, 1'b1, "ur_top");
        check("ur_top_pos",  32'(position_qb), 32'h0);
        check("ur_top_nxt0", 32'(e_next_qb),   32'h0);
        dir_req = 3'd1;
        repeat (3) tick();
        check("offboard_blocked", 32'(e_jump_qb), 32'h0);
        dir_req = 3'd0;
        pulse_respawn();
        check("offboard_respawn", 32'(position_qb), 32'h1);

        // Saucer return after another off-board jump
        do_jump(3'd4, 1'b0, 32'h0, 1'b0, "ul_top");
        check("ul_top_pos", 32'(position_qb), 32'h0);
        sc_arrive = 1'b1;
        tick();
        sc_arrive = 1'b0;
        check("saucer_pos", 32'(position_qb), 32'h1);

        // Left-edge walk down to cube 28, then off the bottom
        for (int i = 0; i < 6; i++) begin
            do_jump(3'd2, 1'b1, DL_EXP[i], 1'b0, $sformatf("dl%0d", i));
        end
        check("dl_pos28", 32'(position_qb), 32'h0800_0000);
        do_jump(3'd1, 1'b1, 32'h0, 1'b1, "dr_bottom");
        check("dr_bottom_pos", 32'(position_qb), 32'h0);
        pulse_respawn();

        // Reset mid-handshake
        dir_req = 3'd1;
        tick();
        dir_req = 3'd0;
        reset = 1'b0;
        #1;
        check("arst_jump",    32'(e_jump_qb),    32'h0);
        check("arst_pos",     32'(position_qb),  32'h1);
        check("arst_visited", 32'(cube_visited), 32'h1);
        @(posedge clk);
        #1 reset = 1'b1;

        // Start timeout: layer never drops done
        dir_req = 3'd1;
        tick();
        dir_req = 3'd0;
        n = 0;
        while (!jump_err && n < 1100) begin
            tick();
            n++;
        end
        check("to_cycles", 32'(n),           32'd1025);
        check("to_err",    32'(jump_err),    32'h1);
        check("to_jump",   32'(e_jump_qb),   32'h0);
        check("to_bad",    32'(e_bad_jump),  32'h0);
        check("to_pos",    32'(position_qb), 32'h1);
        check("to_next",   32'(e_next_qb),   32'h1);
        repeat (3) tick();
        check("to_sticky", 32'(jump_err), 32'h1);

        // Restart during WAIT_END
        pulse_respawn();
        do_jump(3'd1, 1'b0, 32'h0, 1'b0, "pre");
        dir_req = 3'd2;
        tick();
        dir_req = 3'd0;
        tick();
        done_move_qb = 1'b0;
        tick();
        pulse_restart();
        check("rs_pos",     32'(position_qb),  32'h1);
        check("rs_visited", 32'(cube_visited), 32'h1);
        check("rs_jump",    32'(e_jump_qb),    32'h0);
        check("rs_err",     32'(jump_err),     32'h0);
        done_move_qb = 1'b1;
        do_jump(3'd1, 1'b1, 32'h2, 1'b0, "rs_idle");
        check("rs_idle_pos", 32'(position_qb), 32'h2);

        // Full tour for the win flag
        pulse_restart();
        for (int i = 0; i < 30; i++) begin
            if (i == 29) check("win_before", 32'(win_qb), 32'h0);
            do_jump(PATH[i], 1'b0, 32'h0, 1'b0, "tour");
        end
        check("tour_pos",     32'(position_qb),  32'h0800_0000);
        check("tour_visited", 32'(cube_visited), 32'h0FFF_FFFF);
        check("win_same_cyc", 32'(win_qb),       32'h0);
        tick();
        check("win_set", 32'(win_qb), 32'h1);
        repeat (5) tick();
        check("win_hold", 32'(win_qb), 32'h1);
        pulse_restart();
        check("win_clear",     32'(win_qb),       32'h0);
        check("win_clear_vis", 32'(cube_visited), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
